// File: rtl/m_stage_lsu_pkg.sv
// Shared enums for the memory stage: bus op kind, access width, LSU FSM state
// and the writeback control fields forwarded through the M->W register.
package HighLevelControl;

  // Stand-in for the XLEN default normally taken from parameters.svh.
  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {None, Load, Store} memOp;
  typedef enum logic [1:0] {Byte, Half, Word, Double} memWidth;
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} lsuState;
  typedef enum logic [1:0] {Compute, Memory, PcNext} resultSrc;
  typedef enum logic [2:0] {TruncNone, TruncB, TruncBU, TruncH, TruncHU, TruncW, TruncWU} truncType;

endpackage

// File: rtl/m_stage_lsu_store_aligner.sv
// Combinational store lane steering: replicates store data across byte lanes,
// builds byte strobes and flags accesses that are misaligned or too wide.
module m_stage_lsu_store_aligner
  import HighLevelControl::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int OFFW = $clog2(XLEN/8)
) (
  input  memWidth           i_width,
  input  logic [OFFW-1:0]   i_offset,
  input  logic [XLEN-1:0]   i_data,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN/8-1:0] o_wstrb,
  output logic              o_misalign
);
  localparam int NB = XLEN/8;

  int w_nbytes;

  always_comb begin
    o_wdata    = '0;
    o_wstrb    = '0;
    w_nbytes   = 1 << i_width;
    // A width wider than the bus (Double on a 32-bit bus) is treated as misaligned.
    o_misalign = (w_nbytes > NB) || ((int'(i_offset) & (w_nbytes - 1)) != 0);
    for (int i = 0; i < NB; i++) begin
      o_wdata[8*i +: 8] = i_data[8*((i & (w_nbytes - 1)) & (NB - 1)) +: 8];
      o_wstrb[i]        = (i >= int'(i_offset)) && (i < int'(i_offset) + w_nbytes);
    end
  end

endmodule

// File: rtl/m_stage_lsu.sv
// Memory-stage load/store unit: issues aligned data-bus requests, stalls until
// DAck, and registers the M->W pipeline state for writeback.
module m_stage_lsu
  import HighLevelControl::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int OFFW = $clog2(XLEN/8)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              Valid_M,
  input  logic              Flush_M,
  input  logic [XLEN-1:0]   ComputeResult_M,
  input  logic [XLEN-1:0]   WriteData_M,
  input  memOp              MemOp_M,
  input  memWidth           MemWidth_M,
  input  resultSrc          ResultSrc_M,
  input  truncType          TruncType_M,
  output logic              DReq,
  output logic              DWe,
  output logic [XLEN-1:0]   DAddr,
  output logic [XLEN-1:0]   DWData,
  output logic [XLEN/8-1:0] DWStrb,
  input  logic              DAck,
  input  logic [XLEN-1:0]   DRData,
  output logic              Stall_M,
  output logic              Valid_W,
  output logic [XLEN-1:0]   ComputeResult_W,
  output logic [XLEN-1:0]   MemReadData_W,
  output resultSrc          ResultSrc_W,
  output truncType          TruncType_W,
  output logic [OFFW-1:0]   TruncSrc_W,
  output logic              MisalignFault_W,
  output lsuState           o_state_dbg
);
  localparam int NB = XLEN/8;

  lsuState         r_state, w_state_nxt;
  logic [XLEN-1:0] r_addr, r_wdata, r_cres;
  logic [NB-1:0]   r_strb;
  logic            r_we;
  logic [OFFW-1:0] r_off;
  resultSrc        r_rsrc;
  truncType        r_trunc;

  logic [XLEN-1:0] w_al_wdata;
  logic [NB-1:0]   w_al_strb;
  logic            w_misalign, w_is_mem, w_mem_ok, w_busy, w_idle_req, w_latch;
  logic [OFFW-1:0] w_m_off;

  logic            w_wv, w_wfault;
  logic [XLEN-1:0] w_wcres, w_wrdata;
  resultSrc        w_wsrc;
  truncType        w_wtrunc;
  logic [OFFW-1:0] w_woff;

  m_stage_lsu_store_aligner #(.XLEN(XLEN), .OFFW(OFFW)) u_aligner (
    .i_width    (MemWidth_M),
    .i_offset   (w_m_off),
    .i_data     (WriteData_M),
    .o_wdata    (w_al_wdata),
    .o_wstrb    (w_al_strb),
    .o_misalign (w_misalign)
  );

  assign w_m_off     = ComputeResult_M[OFFW-1:0];
  assign w_is_mem    = Valid_M && (MemOp_M != None);
  assign w_mem_ok    = w_is_mem && !w_misalign;
  assign w_busy      = (r_state != IDLE);
  assign w_idle_req  = (r_state == IDLE) && w_mem_ok && !Flush_M;
  assign w_latch     = w_idle_req && !DAck;
  assign o_state_dbg = r_state;

  // Bus outputs: live M fields on the first cycle, latched fields afterwards.
  // DReq is gated by reset so the request drops the moment reset asserts.
  always_comb begin
    DReq   = (w_busy || w_idle_req) && reset_n;
    DWe    = 1'b0;
    DAddr  = '0;
    DWData = '0;
    DWStrb = '0;
    if (DReq) begin
      if (w_busy) begin
        DWe    = r_we;
        DAddr  = r_addr;
        DWData = r_wdata;
        DWStrb = r_strb;
      end else begin
        DWe    = (MemOp_M == Store);
        DAddr  = {ComputeResult_M[XLEN-1:OFFW], {OFFW{1'b0}}};
        DWData = w_al_wdata;
        DWStrb = w_al_strb;
      end
    end
    Stall_M = DReq && !DAck;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_latch) w_state_nxt = WAIT;
      WAIT:    if (DAck) w_state_nxt = IDLE;
               else if (Flush_M) w_state_nxt = DRAIN;
      DRAIN:   if (DAck) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_off   <= '0;
      r_cres  <= '0;
      r_rsrc  <= Compute;
      r_trunc <= TruncNone;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_we    <= (MemOp_M == Store);
        r_addr  <= DAddr;
        r_wdata <= w_al_wdata;
        r_strb  <= w_al_strb;
        r_off   <= w_m_off;
        r_cres  <= ComputeResult_M;
        r_rsrc  <= ResultSrc_M;
        r_trunc <= TruncType_M;
      end
    end
  end

  // W next value; anything other than a completed or non-memory op is a bubble.
  always_comb begin
    w_wv     = 1'b0;
    w_wfault = 1'b0;
    w_wcres  = '0;
    w_wrdata = '0;
    w_wsrc   = Compute;
    w_wtrunc = TruncNone;
    w_woff   = '0;
    if (!Stall_M) begin
      if ((r_state == WAIT) && DAck && !Flush_M) begin
        w_wv     = 1'b1;
        w_wcres  = r_cres;
        w_wrdata = r_we ? '0 : DRData;
        w_wsrc   = r_rsrc;
        w_wtrunc = r_trunc;
        w_woff   = r_off;
      end else if ((r_state == IDLE) && Valid_M && !Flush_M) begin
        w_wv     = 1'b1;
        w_wcres  = ComputeResult_M;
        w_wsrc   = ResultSrc_M;
        w_wtrunc = TruncType_M;
        if (w_is_mem) begin
          w_woff   = w_m_off;
          w_wfault = w_misalign;
          if (!w_misalign && (MemOp_M == Load)) w_wrdata = DRData;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Valid_W         <= 1'b0;
      MisalignFault_W <= 1'b0;
      ComputeResult_W <= '0;
      MemReadData_W   <= '0;
      ResultSrc_W     <= Compute;
      TruncType_W     <= TruncNone;
      TruncSrc_W      <= '0;
    end else begin
      Valid_W         <= w_wv;
      MisalignFault_W <= w_wfault;
      ComputeResult_W <= w_wcres;
      MemReadData_W   <= w_wrdata;
      ResultSrc_W     <= w_wsrc;
      TruncType_W     <= w_wtrunc;
      TruncSrc_W      <= w_woff;
    end
  end

endmodule

// File: tb/tb_m_stage_lsu.sv
// Directed bench for m_stage_lsu (XLEN=32): bus-side checks inline, W-side
// results checked by a monitor against an expected queue.
module tb_m_stage_lsu;
  import HighLevelControl::*;

  localparam int XLEN = 32;
  localparam int W    = 72;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            Valid_M, Flush_M, DAck;
  logic [XLEN-1:0] ComputeResult_M, WriteData_M, DRData;
  memOp            MemOp_M;
  memWidth         MemWidth_M;
  resultSrc        ResultSrc_M;
  truncType        TruncType_M;
  logic            DReq, DWe, Stall_M, Valid_W, MisalignFault_W;
  logic [XLEN-1:0] DAddr, DWData, ComputeResult_W, MemReadData_W;
  logic [3:0]      DWStrb;
  resultSrc        ResultSrc_W;
  truncType        TruncType_W;
  logic [1:0]      TruncSrc_W;
  lsuState         state_dbg;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  m_stage_lsu #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .Valid_M(Valid_M), .Flush_M(Flush_M),
    .ComputeResult_M(ComputeResult_M), .WriteData_M(WriteData_M),
    .MemOp_M(MemOp_M), .MemWidth_M(MemWidth_M), .ResultSrc_M(ResultSrc_M),
    .TruncType_M(TruncType_M), .DReq(DReq), .DWe(DWe), .DAddr(DAddr),
    .DWData(DWData), .DWStrb(DWStrb), .DAck(DAck), .DRData(DRData),
    .Stall_M(Stall_M), .Valid_W(Valid_W), .ComputeResult_W(ComputeResult_W),
    .MemReadData_W(MemReadData_W), .ResultSrc_W(ResultSrc_W),
    .TruncType_W(TruncType_W), .TruncSrc_W(TruncSrc_W),
    .MisalignFault_W(MisalignFault_W), .o_state_dbg(state_dbg)
  );

  function automatic logic [W-1:0] pk(input logic [31:0] cres, input logic [31:0] rdata,
                                      input logic fault, input logic [1:0] off,
                                      input resultSrc rs, input truncType tt);
    return {cres, rdata, fault, off, rs, tt};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Valid_M = 1'b0; Flush_M = 1'b0; DAck = 1'b0; DRData = '0;
    ComputeResult_M = '0; WriteData_M = '0; MemOp_M = None; MemWidth_M = Byte;
    ResultSrc_M = Compute; TruncType_M = TruncNone;
  endtask

  task automatic drive(input memOp op, input memWidth wd, input logic [31:0] a,
                       input logic [31:0] d, input resultSrc rs, input truncType tt);
    Valid_M = 1'b1; Flush_M = 1'b0; MemOp_M = op; MemWidth_M = wd;
    ComputeResult_M = a; WriteData_M = d; ResultSrc_M = rs; TruncType_M = tt;
  endtask

  // Monitor: every valid W output must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n && Valid_W) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL w_unexpected: got valid W cres=%0h, none expected", ComputeResult_W);
      end else begin
        check("w_fields", {ComputeResult_W, MemReadData_W, MisalignFault_W, TruncSrc_W,
                           ResultSrc_W, TruncType_W}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    total++; bad++;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dreq", DReq, 0);
    check("rst_stall", Stall_M, 0);
    check("rst_valid_w", Valid_W, 0);
    check("rst_fault", MisalignFault_W, 0);
    check("rst_rsrc", ResultSrc_W, Compute);
    check("rst_cres", ComputeResult_W, 0);
    check("rst_state", state_dbg, IDLE);
    step();
    reset_n = 1'b1;

    // Zero-wait stores: byte, half, word lanes.
    drive(Store, Byte, 32'h1003, 32'hAB, Compute, TruncNone); DAck = 1'b1;
    exp_q.push_back(pk(32'h1003, 0, 0, 2'd3, Compute, TruncNone));
    @(negedge clk);
    check("sb_dreq", DReq, 1); check("sb_dwe", DWe, 1); check("sb_daddr", DAddr, 32'h1000);
    check("sb_strb", DWStrb, 4'b1000); check("sb_wdata", DWData, 32'hABABABAB);
    check("sb_stall", Stall_M, 0);
    step();
    drive(Store, Half, 32'h1002, 32'h1234, Compute, TruncNone); DAck = 1'b1;
    exp_q.push_back(pk(32'h1002, 0, 0, 2'd2, Compute, TruncNone));
    @(negedge clk);
    check("sh_strb", DWStrb, 4'b1100); check("sh_wdata", DWData, 32'h12341234);
    check("sh_stall", Stall_M, 0);
    step();
    drive(Store, Word, 32'h1004, 32'h89ABCDEF, Compute, TruncNone); DAck = 1'b1;
    exp_q.push_back(pk(32'h1004, 0, 0, 2'd0, Compute, TruncNone));
    @(negedge clk);
    check("sw_daddr", DAddr, 32'h1004); check("sw_strb", DWStrb, 4'b1111);
    check("sw_wdata", DWData, 32'h89ABCDEF);
    step();

    // Word load with three wait states.
    drive(Load, Word, 32'h2000, 0, Memory, TruncW); DAck = 1'b0; DRData = 32'h12345678;
    exp_q.push_back(pk(32'h2000, 32'hDEADBEEF, 0, 2'd0, Memory, TruncW));
    stall_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("lw_wait_dreq", DReq, 1); check("lw_wait_daddr", DAddr, 32'h2000);
      check("lw_wait_dwe", DWe, 0);
      if (Stall_M) stall_cnt++;
      if (c > 0) check("lw_wait_bubble", Valid_W, 0);
      step();
    end
    DAck = 1'b1; DRData = 32'hDEADBEEF;
    @(negedge clk);
    check("lw_ack_dreq", DReq, 1); check("lw_ack_stall", Stall_M, 0);
    check("lw_stall_cycles", stall_cnt, 3);
    step();
    idle_inputs();

    // Misaligned half load with a stray DAck: no request, fault to W.
    drive(Load, Half, 32'h2001, 0, Memory, TruncH); DAck = 1'b1; DRData = 32'hFFFFFFFF;
    exp_q.push_back(pk(32'h2001, 0, 1, 2'd1, Memory, TruncH));
    @(negedge clk);
    check("mis_dreq", DReq, 0); check("mis_stall", Stall_M, 0);
    step();
    idle_inputs();
    @(negedge clk);
    check("mis_fault_w", MisalignFault_W, 1); check("mis_state", state_dbg, IDLE);
    step();

    // Back-to-back ALU ops.
    drive(None, Byte, 32'h55, 0, Compute, TruncNone);
    exp_q.push_back(pk(32'h55, 0, 0, 2'd0, Compute, TruncNone));
    @(negedge clk);
    check("alu_stall", Stall_M, 0); check("alu_dreq", DReq, 0);
    step();
    drive(None, Byte, 32'hAA, 0, PcNext, TruncNone);
    exp_q.push_back(pk(32'hAA, 0, 0, 2'd0, PcNext, TruncNone));
    @(negedge clk);
    check("alu2_stall", Stall_M, 0);
    step();
    idle_inputs();

    // Flush in IDLE: no request, bubble.
    drive(Load, Word, 32'h6000, 0, Memory, TruncW); Flush_M = 1'b1;
    @(negedge clk);
    check("fi_dreq", DReq, 0);
    step();
    idle_inputs();
    @(negedge clk);
    check("fi_bubble", Valid_W, 0);
    step();

    // Flush in the second wait cycle, DAck two cycles later.
    drive(Load, Word, 32'h3000, 0, Memory, TruncW);
    @(negedge clk);
    check("fw_req_stall", Stall_M, 1);
    step();
    @(negedge clk);
    check("fw_state_wait", state_dbg, WAIT);
    step();
    Flush_M = 1'b1;
    @(negedge clk);
    check("fw_flush_dreq", DReq, 1); check("fw_flush_stall", Stall_M, 1);
    step();
    idle_inputs();
    @(negedge clk);
    check("fw_state_drain", state_dbg, DRAIN); check("fw_drain_dreq", DReq, 1);
    check("fw_drain_daddr", DAddr, 32'h3000); check("fw_drain_stall", Stall_M, 1);
    step();
    DAck = 1'b1; DRData = 32'hCAFEF00D;
    @(negedge clk);
    check("fw_ack_dreq", DReq, 1);
    step();
    idle_inputs();
    @(negedge clk);
    check("fw_bubble", Valid_W, 0); check("fw_state_idle", state_dbg, IDLE);
    step();

    // Flush and DAck in the same WAIT cycle.
    drive(Load, Word, 32'h5000, 0, Memory, TruncW);
    step();
    Flush_M = 1'b1; DAck = 1'b1; DRData = 32'h0BADF00D;
    @(negedge clk);
    check("fa_stall", Stall_M, 0);
    step();
    idle_inputs();
    @(negedge clk);
    check("fa_bubble", Valid_W, 0); check("fa_state", state_dbg, IDLE);
    step();

    // Reset asserted mid-WAIT.
    drive(Load, Word, 32'h4000, 0, Memory, TruncW);
    step();
    @(negedge clk);
    check("rw_state_wait", state_dbg, WAIT);
    #1 reset_n = 1'b0;
    #1;
    check("rw_dreq", DReq, 0); check("rw_valid_w", Valid_W, 0);
    check("rw_stall", Stall_M, 0); check("rw_state", state_dbg, IDLE);
    step();
    idle_inputs();
    reset_n = 1'b1;
    step();

    // Recovery after reset.
    drive(None, Byte, 32'h77, 0, Compute, TruncNone);
    exp_q.push_back(pk(32'h77, 0, 0, 2'd0, Compute, TruncNone));
    step();
    idle_inputs();
    @(negedge clk);
    step();

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m_stage_lsu.md
# m_stage_lsu

Memory-stage load/store unit, between the execute-stage pipeline register and the writeback stage. Issues aligned data-bus requests for loads and stores and stalls the pipeline until the bus acknowledges. Registers the M→W pipeline state, presenting the computed result, raw read word, result select, truncation type and byte offset to writeback. Non-memory instructions pass through with one cycle of latency and no stall.

## Interface
- `XLEN`: default from `parameters.svh` (32 or 64); datapath width.
- `OFFW`: default `$clog2(XLEN/8)`; byte-offset width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` — in — 1 — rising-edge clock
- `reset_n` — in — 1 — async active-low reset
- `Valid_M` — in — 1 — M-stage instruction valid
- `Flush_M` — in — 1 — kill M-stage instruction
- `ComputeResult_M` — in — XLEN — ALU result; byte address for memory ops
- `WriteData_M` — in — XLEN — store data, LSB-aligned
- `MemOp_M` — in — memOp — None / Load / Store
- `MemWidth_M` — in — memWidth — Byte / Half / Word / Double (Double only if XLEN=64)
- `ResultSrc_M` — in — resultSrc — forwarded to W
- `TruncType_M` — in — truncType — forwarded to W
- `DReq` — out — 1 — bus request
- `DWe` — out — 1 — 1 = store
- `DAddr` — out — XLEN — address, low OFFW bits zero
- `DWData` — out — XLEN — lane-shifted store data
- `DWStrb` — out — XLEN/8 — byte-write strobes
- `DAck` — in — 1 — one-cycle completion pulse
- `DRData` — in — XLEN — read word, valid with DAck
- `Stall_M` — out — 1 — freeze F/D/E/M
- `Valid_W`, `ComputeResult_W`, `MemReadData_W`, `ResultSrc_W`, `TruncType_W`, `TruncSrc_W` (OFFW), `MisalignFault_W` — out — M→W register outputs

## Operation
- States: IDLE, WAIT, DRAIN.
- An instruction is a memory op when `Valid_M` and `MemOp_M != None` and it is aligned: Half needs addr[0]=0, Word addr[1:0]=0, Double addr[2:0]=0.
- Misaligned op: no bus request, no stall. W loads with `Valid_W=1`, `MisalignFault_W=1`, and `MemReadData_W=0`.
- IDLE with a memory op and no flush: drive `DReq`, `DWe`, `DAddr`, `DWData`, `DWStrb` combinationally from the M inputs.
  - `DAck` in the same cycle: load W, stay in IDLE, no stall.
  - Otherwise: latch the request fields, go to WAIT, assert `Stall_M`.
- WAIT: drive the bus from the latched fields and hold `Stall_M=1`. On `DAck`, load W and go to IDLE.
- `Flush_M` in WAIT: go to DRAIN. The bus transaction cannot be cancelled, so `DReq` stays high and `Stall_M` stays high. On `DAck`, discard the data, load a bubble (`Valid_W=0`), go to IDLE.
- `Flush_M` in IDLE: no request; W gets a bubble.
- Store lanes: `DWData` = data replicated across lanes. `DWStrb` = (1<<bytes)−1 shifted left by addr[OFFW-1:0].
- Load: `MemReadData_W` = raw `DRData`. `TruncSrc_W` = addr[OFFW-1:0]. Writeback performs shift and extension.
- Non-memory op: W loads every non-stalled cycle with the M fields; `MemReadData_W=0`.
- While `Stall_M=1`, W holds a bubble (`Valid_W=0`).

## Timing
- Reset values: state=IDLE, `DReq=0`, `Stall_M=0`, `Valid_W=0`, `MisalignFault_W=0`, `ResultSrc_W=Compute`, all data outputs 0.
- Latency M→W: 1 cycle for zero-wait memory ops and non-memory ops; 1+N cycles for an N-wait-state access.
- `DReq` stays high and the request fields stay stable from the first request cycle until `DAck`.
- `DAck` outside a request is ignored.
- `reset_n` low mid-WAIT: return to IDLE immediately and drop `DReq`. The bus is required to be reset together with this block.
- `Flush_M` and `DAck` in the same WAIT cycle: data discarded, bubble to W, IDLE next.

## Structure
- `HighLevelControl` package gains:
  - `memOp` enum: None, Load, Store.
  - `memWidth` enum: Byte, Half, Word, Double.
  - `lsuState` enum: IDLE, WAIT, DRAIN.
- Sub-module `store_aligner`: combinational. Inputs: width, offset, data. Outputs: `DWData`, `DWStrb`, misalign flag.
- FSM, request latches and W register stay in `m_stage_lsu`.

## Test plan
- XLEN=32, store Byte 0xAB at address 0x1003, `DAck` same cycle → `DAddr=0x1000`, `DWStrb=4'b1000`, `DWData=0xABABABAB`, `Stall_M=0`.
- Load Word at 0x2000, `DAck` after 3 cycles with `DRData=0xDEADBEEF` → `Stall_M` high for 3 cycles, then `MemReadData_W=0xDEADBEEF`, `TruncSrc_W=0`, `Valid_W=1`.
- Load Half at 0x2001 → no `DReq`; next cycle `MisalignFault_W=1`, `Valid_W=1`.
- Load at 0x3000, `Flush_M` in the second wait cycle, `DAck` 2 cycles later → `DReq` held until `DAck`, then `Valid_W=0`, state IDLE.
- ALU op with result 0x55, `ResultSrc_M=Compute` → next cycle `ComputeResult_W=0x55`, no stall; reset asserted mid-WAIT → `DReq=0` and `Valid_W=0` immediately.
